// File: rtl/bus_arbiter_pkg.sv
// Shared bus-master definitions for the round-robin bus arbiter: master count,
// owner index type, owner encodings, active-low enable levels and the grant
// decode helper.
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W   = 2;

  typedef logic [BUS_OWNER_W-1:0] BusOwnerBus;

  localparam BusOwnerBus BUS_OWNER_MASTER_0 = 2'd0;
  localparam BusOwnerBus BUS_OWNER_MASTER_1 = 2'd1;
  localparam BusOwnerBus BUS_OWNER_MASTER_2 = 2'd2;
  localparam BusOwnerBus BUS_OWNER_MASTER_3 = 2'd3;

  // Active-low control levels used on every request/grant/strobe line.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // One-hot active-low grant vector for a given owner.
  function automatic logic [BUS_MASTER_CH-1:0] grant_decode(input BusOwnerBus owner);
    logic [BUS_MASTER_CH-1:0] g;
    g        = {BUS_MASTER_CH{DISABLE_}};
    g[owner] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin scan: starting just after the current owner, finds
// the first requesting master among owner+1, owner+2, owner+3 (modulo 4).
// The owner itself is never considered. found is low when nobody else asks.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  BusOwnerBus               owner,
  input  logic [BUS_MASTER_CH-1:0] req,
  output BusOwnerBus               next_owner,
  output logic                     found
);

  BusOwnerBus cand;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    cand       = owner;
    for (int k = BUS_MASTER_CH - 1; k >= 1; k--) begin
      // Two-bit wrap gives the modulo-4 rotation for free.
      cand = owner + BUS_OWNER_W'(k);
      if (req[cand]) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the four SoC bus masters. Owner, grants and the
// watchdog strobe are all registered; exactly one grant is asserted at all
// times. Optional watchdog compiled in with `define BUS_ARB_TIMEOUT_EN:
// after TIMEOUT_CYCLES contended hold cycles the owner is forced to rotate.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output BusOwnerBus bus_owner,
  output logic       arb_timeout_
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  logic [BUS_MASTER_CH-1:0] req;
  logic [BUS_MASTER_CH-1:0] grnt_q;
  BusOwnerBus               owner_q;
  BusOwnerBus               owner_nxt;
  BusOwnerBus               pick_owner;
  logic                     pick_found;
  logic                     owner_req;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req = req[owner_q];

  bus_arb_rr_pick u_pick (
    .owner      (owner_q),
    .req        (req),
    .next_owner (pick_owner),
    .found      (pick_found)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;
  logic             contend;
  logic             expire;

  // Contended hold: owner keeps asking while someone else is waiting.
  assign contend = owner_req & pick_found;
  assign expire  = contend && (hold_cnt == CNT_LAST);
`endif

  // Next owner: hand off on release, optionally force rotation on expiry.
  always_comb begin
    owner_nxt = owner_q;
    if (!owner_req && pick_found) begin
      owner_nxt = pick_owner;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    else if (expire) begin
      owner_nxt = pick_owner;
    end
`endif
  end

  // Owner and grant flops update together so grants never glitch.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_q <= BUS_OWNER_MASTER_0;
      grnt_q  <= grant_decode(BUS_OWNER_MASTER_0);
    end else begin
      owner_q <= owner_nxt;
      grnt_q  <= grant_decode(owner_nxt);
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Watchdog: count contended holds; rotation or any gap clears the count.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      hold_cnt  <= '0;
      timeout_q <= DISABLE_;
    end else begin
      timeout_q <= expire ? ENABLE_ : DISABLE_;
      if (!contend || (owner_nxt != owner_q)) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

  assign arb_timeout_ = timeout_q;
`else
  assign arb_timeout_ = DISABLE_;
`endif

  assign bus_owner = owner_q;
  assign m0_grnt_  = grnt_q[0];
  assign m1_grnt_  = grnt_q[1];
  assign m2_grnt_  = grnt_q[2];
  assign m3_grnt_  = grnt_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random request
// traffic, with a behavioural round-robin model producing expected owner and
// watchdog strobe values. Models the watchdog when BUS_ARB_TIMEOUT_EN is set.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       m0_req_ = 1'b1, m1_req_ = 1'b1, m2_req_ = 1'b1, m3_req_ = 1'b1;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] bus_owner;
  logic       arb_timeout_;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int owner;
    bit tout_n;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m_owner = 0;
  int m_hold  = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .m0_req_      (m0_req_),
    .m1_req_      (m1_req_),
    .m2_req_      (m2_req_),
    .m3_req_      (m3_req_),
    .m0_grnt_     (m0_grnt_),
    .m1_grnt_     (m1_grnt_),
    .m2_grnt_     (m2_grnt_),
    .m3_grnt_     (m3_grnt_),
    .bus_owner    (bus_owner),
    .arb_timeout_ (arb_timeout_)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected outcome of one clock edge given active-high requests r.
  task automatic model_step(input logic [3:0] r);
    exp_t e;
    int   first;
    int   nxt;
    bit   tout_n;
    first  = -1;
    for (int k = 1; k <= 3; k++) begin
      if (first < 0 && r[(m_owner + k) % 4]) first = (m_owner + k) % 4;
    end
    nxt    = m_owner;
    tout_n = 1'b1;
    if (!r[m_owner]) begin
      if (first >= 0) nxt = first;
      m_hold = 0;
    end else if (first >= 0) begin
`ifdef BUS_ARB_TIMEOUT_EN
      m_hold = m_hold + 1;
      if (m_hold == TO) begin
        nxt    = first;
        tout_n = 1'b0;
      end
`endif
    end else begin
      m_hold = 0;
    end
    if (nxt != m_owner) m_hold = 0;
    m_owner  = nxt;
    e.owner  = nxt;
    e.tout_n = tout_n;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r);
    @(negedge clk);
    m0_req_ = ~r[0];
    m1_req_ = ~r[1];
    m2_req_ = ~r[2];
    m3_req_ = ~r[3];
    model_step(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_owner"}, int'(bus_owner), 0);
    chk({tag, "_grants"}, int'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 4'b1110);
    chk({tag, "_timeout"}, int'(arb_timeout_), 1);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin
    exp_t       e;
    logic [3:0] eg;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e         = exp_q.pop_front();
        eg        = 4'b1111;
        eg[e.owner] = 1'b0;
        chk("owner", int'(bus_owner), e.owner);
        chk("grants", int'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), int'(eg));
        chk("timeout", int'(arb_timeout_), int'(e.tout_n));
      end
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL time_limit actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] r;
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset_ = 1'b1;

    // Hold and hand-off
    drive(4'b0001);
    drive(4'b0001);
    drive(4'b0101);
    drive(4'b0100);
    drive(4'b0100);

    // Simultaneous requests resolved by scan order
    drive(4'b0001);
    drive(4'b0001);
    drive(4'b1011);
    drive(4'b1010);
    drive(4'b1011);
    drive(4'b1001);

    // Park on master 3, then re-request
    drive(4'b1000);
    repeat (10) drive(4'b0000);
    repeat (3) drive(4'b1000);
    drive(4'b0000);

    // Watchdog: m0 holds while m1 waits
    drive(4'b0001);
    drive(4'b0001);
    repeat (1000) drive(4'b0011);
    drive(4'b0000);

    // Random traffic with sticky requests
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(r);
    end

    // Asynchronous reset while owner is 2
    drive(4'b0100);
    drive(4'b0100);
    @(posedge clk);
    #3;
    reset_ = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    m0_req_ = 1'b1; m1_req_ = 1'b1; m2_req_ = 1'b1; m3_req_ = 1'b1;
    m_owner = 0;
    m_hold  = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    reset_ = 1'b1;

    // Traffic after reset, including contention
    repeat (8) drive(4'b0110);
    for (int i = 0; i < 300; i++) drive(4'($urandom_range(0, 15)));

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter for the four SoC bus masters. It owns the single shared bus: each cycle it decides which master drives the address/control path. The slave read-data/ready return path is selected separately by address decode. Grants are registered and held for as long as the owner keeps requesting. An optional watchdog forcibly rotates ownership away from a master that starves the others.

## Interface
- TIMEOUT_CYCLES, 256: qualifying hold cycles before forced rotation; must be ≥ 2; only used with BUS_ARB_TIMEOUT_EN.
- clk  input  1  bus clock, all state on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- m0_req_ … m3_req_  input  1 each  active-low bus request from master n.
- m0_grnt_ … m3_grnt_  output  1 each  active-low grant, registered, exactly one asserted at all times.
- bus_owner  output  2 (`BusOwnerBus`)  index of the current owner, registered.
- arb_timeout_  output  1  active-low one-cycle pulse when the watchdog forced a rotation.

## Operation
- State is the owner register, 2 bits, with values 0–3. Grants are the one-hot active-low decode of the owner. Grant flops are updated together with the owner register; they are not a combinational decode at the output.
- Owner keeps the bus: if the current owner's req_ is `ENABLE_`, the owner is unchanged (subject to the timeout).
- Owner releases: if the current owner's req_ is `DISABLE_`, scan the other masters in order owner+1, owner+2, owner+3, modulo 4. The first requesting master becomes the next owner.
- No requests: if no other master is requesting, the owner stays (bus parked). A parked owner that re-requests proceeds with no extra latency.
- Simultaneous requests are resolved purely by the round-robin scan order relative to the current owner. No master has fixed priority.
- Watchdog (BUS_ARB_TIMEOUT_EN only):
  - hold_cnt, width $clog2(TIMEOUT_CYCLES), increments in every cycle where the owner's req_ is `ENABLE_` and at least one other req_ is `ENABLE_`.
  - hold_cnt clears to 0 on any owner change, and in any cycle where that condition is false.
  - When hold_cnt == TIMEOUT_CYCLES-1 and the condition holds, the next edge does three things: owner ← first other requester in scan order, hold_cnt ← 0, and arb_timeout_ ← `ENABLE_` for exactly one cycle.
  - The counter saturates structurally because the rotation clears it. It never wraps.

## Timing
- Reset values: owner = 0; m0_grnt_ = `ENABLE_`; m1..m3_grnt_ = `DISABLE_`; bus_owner = 2'd0; arb_timeout_ = `DISABLE_`; hold_cnt = 0.
- Reset is asynchronous: when reset_ is asserted mid-transfer, the outputs go to their reset values immediately, without waiting for a clock edge.
- Decision latency is 1 cycle. Request and release values sampled at edge N take effect on grants and bus_owner after edge N.
- Hand-off: if the owner deasserts req_ in cycle N and a requester is waiting, the new grant appears in cycle N+1. There is never a cycle with zero or two grants.
- A master must hold req_ asserted until it has seen its grant. Requests that drop before the grant are simply not served.
- Forced rotation: with other requesters pending continuously, the owner loses its grant after exactly TIMEOUT_CYCLES qualifying cycles. arb_timeout_ is asserted in the same cycle the new grant appears.

## Configuration
- BUS_ARB_TIMEOUT_EN defined: the watchdog counter and arb_timeout_ logic are compiled in, as described above.
- BUS_ARB_TIMEOUT_EN undefined: there is no counter, and arb_timeout_ is tied to `DISABLE_`. An owner may hold the bus indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Shared in bus.h:
  - `BUS_MASTER_CH` (4).
  - `BUS_OWNER_W` (2) and `BusOwnerBus`.
  - `BUS_OWNER_MASTER_0` … `BUS_OWNER_MASTER_3`.
  - The existing `ENABLE_`/`DISABLE_` definitions from stddef.h.
- One sub-module: bus_arb_rr_pick. It is combinational. Inputs are the current owner and the 4-bit active-high request vector. Outputs are the next owner and a "found" flag, implementing the owner+1..owner+3 scan. The top level holds the owner, grant and counter flops.

## Test plan
- Reset: assert reset_ = 0 mid-run with owner 2 → bus_owner = 0 and m0_grnt_ = 0 immediately, other grants = 1, arb_timeout_ = 1.
- Hold and hand-off: m0 requesting, m2 raises req_ → grant unchanged. m0 drops req_ at cycle N → bus_owner = 2 and m2_grnt_ = 0 at N+1.
- Simultaneous: owner 0 releases while m1 and m3 request → owner 1. Then m1 releases while m3 and m0 request → owner 3, not 0.
- Park: all req_ high for 10 cycles with owner 3 → owner stays 3, m3_grnt_ = 0 throughout. m3 then re-requests with no grant glitch.
- Timeout (macro on, TIMEOUT_CYCLES = 4): m0 holds and m1 requests continuously → after 4 qualifying cycles, owner = 1 and arb_timeout_ = 0 for exactly one cycle.
- Timeout with the macro off: same stimulus for 1000 cycles → owner stays 0 and arb_timeout_ stays 1.
